lsu_handshake: RTL and testbench
================================

# lsu_handshake

Parametrised load/store unit that sits between the multi-cycle core sequencer and the byte-addressable memory. It replaces the fixed fetch/access wait states with a valid/ready request port and an ack-based bus, so memories of any latency can be attached. It also handles byte-lane steering, sign/zero extension of loads, misalignment detection and bus timeout.

## Interface
- XLEN, 32: data width; must be 32 or 64.
- ADDR_W, 32: byte address width.
- TIMEOUT, 255: cycles of unacknowledged bus_req before a timeout error; must be ≥1.
- clk  in  1  clock; all logic is rising-edge.
- rst  in  1  reset, asynchronous, active-low.
- req_valid  in  1  core presents an access.
- req_ready  out  1  unit idle and able to accept.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  access size: 0 = byte, 1 = half, 2 = word, 3 = dword (dword legal only when XLEN=64).
- req_unsigned  in  1  zero-extend the load instead of sign-extending it.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  XLEN  store data, right-justified.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  XLEN  extended load data; 0 for stores and for errors.
- resp_err  out  2  0 = ok, 1 = misaligned, 2 = timeout, 3 = illegal size.
- bus_req  out  1  bus transaction active.
- bus_we  out  1  write strobe.
- bus_be  out  XLEN/8  byte enables; bit i is lane i, little-endian.
- bus_addr  out  ADDR_W  word-aligned address (low log2(XLEN/8) bits = 0).
- bus_wdata  out  XLEN  lane-steered write data.
- bus_rdata  in  XLEN  read data, valid when bus_ack = 1.
- bus_ack  in  1  slave completes the current transaction.

## Operation
- States: IDLE, BUS, BUS2, RESP.
- IDLE: req_ready = 1. The unit accepts a request when req_valid & req_ready and latches all req_* fields.
- Size 3 with XLEN=32 → RESP with err = 3; no bus activity.
- Aligned means addr mod (1<<size) = 0. An aligned request → BUS.
- A misaligned request goes to RESP with err = 1 and no bus activity, unless LSU_MISALIGN_SPLIT_EN is defined.
- BUS: bus_req = 1. All bus_* outputs are held stable until bus_ack.
  - lane = addr mod (XLEN/8).
  - bus_be = ((1<<(1<<size))-1) << lane.
  - bus_wdata = wdata << (8*lane).
  - On bus_ack the unit captures bus_rdata and goes to RESP (or to BUS2 when splitting).
- Load result: the captured data is shifted right by 8*lane, truncated to the access size, then sign- or zero-extended to XLEN.
- Timeout counter:
  - Cleared on entry to BUS or BUS2.
  - Increments every cycle bus_req = 1 and bus_ack = 0.
  - When it reaches TIMEOUT, bus_req drops and the unit goes to RESP with err = 2.
  - A late ack after the timeout is ignored.
- RESP: resp_valid = 1 for exactly one cycle, then the unit returns to IDLE. req_ready = 0 in RESP.
- bus_ack outside BUS/BUS2 is ignored.
- Reset values: req_ready = 1, and every other output is 0, including resp_err and bus_be. State = IDLE.
- Reset asserted mid-transaction drops bus_req immediately (asynchronously) and discards the transaction; no resp_valid is issued.

## Timing
- Accept at edge N. bus_req is high from cycle N+1.
- If ack arrives in cycle N+1, resp_valid is in cycle N+2. Minimum latency is 2 cycles.
- Each extra wait cycle of the slave adds exactly 1 cycle of latency.
- Error without bus activity (misaligned or illegal size): resp_valid in cycle N+1.
- Timeout: bus_req is high for exactly TIMEOUT cycles; resp_valid follows in the next cycle.
- Back-to-back throughput: one request per 3 cycles at zero wait. req_ready reasserts in the cycle after resp_valid.
- Outputs are registered, except req_ready, which is decoded from state.

## Configuration
- LSU_MISALIGN_SPLIT_EN defined:
  - A misaligned access that crosses a word boundary runs as two transactions: BUS (low word, upper lanes enabled), then BUS2 (bus_addr + XLEN/8, remaining low lanes).
  - Load data from the two beats is concatenated before extension.
  - The timeout applies per beat. A timeout in either beat aborts with err = 2; the first beat of a store stays committed.
  - A misaligned access inside one word (e.g. half at addr 1, XLEN=32) uses a single beat.
- Not defined: BUS2 does not exist, and every misaligned access returns err = 1 with no bus activity.

## Test plan
- Aligned word load addr 0x10, bus_rdata 0x80FF1234, ack in the first BUS cycle → bus_be 0xF, bus_addr 0x10, resp_valid 2 cycles after accept, rdata 0x80FF1234, err 0.
- Signed byte load addr 0x13 with bus_rdata 0x80FF1234, then the same load unsigned → signed gives rdata 0xFFFFFF80 and be 0x8; unsigned gives rdata 0x00000080.
- Half store addr 0x22 wdata 0x0000BEEF with ack delayed 3 cycles → be 0xC, wdata 0xBEEF0000, bus signals stable for 4 cycles, resp 5 cycles after accept.
- Word load addr 0x05 → macro off: err 1 next cycle, bus_req never high. Macro on: beats at 0x04 (be 0xE) and 0x08 (be 0x1), rdata assembled correctly.
- TIMEOUT=4, no ack → bus_req high exactly 4 cycles, then resp err 2, rdata 0; an ack one cycle later is ignored.
- rst low while in BUS → bus_req 0 in the same cycle, no resp_valid, req_ready 1 after release.

Source files
------------

// File: rtl/lsu_handshake_if.sv
// ---------------------------------------------------------------------------
// lsu_handshake_if
//
// Groups the signals between the core sequencer, the load/store unit and the
// byte-addressable memory bus.
//
// Parameters:
//   XLEN   data width (32 or 64)
//   ADDR_W byte address width
//
// Signal groups:
//   request  : req_valid, req_ready, req_we, req_size, req_unsigned,
//              req_addr, req_wdata
//   response : resp_valid, resp_rdata, resp_err
//   bus      : bus_req, bus_we, bus_be, bus_addr, bus_wdata, bus_rdata,
//              bus_ack
//
// Modports:
//   slave  : the load/store unit. It receives requests from the core and
//            drives the memory bus.
//   master : the environment, meaning the core plus the memory. It issues
//            requests and answers bus transactions.
// ---------------------------------------------------------------------------
interface lsu_handshake_if #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
);
  // request / response
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [XLEN-1:0]   req_wdata;
  logic              resp_valid;
  logic [XLEN-1:0]   resp_rdata;
  logic [1:0]        resp_err;

  // memory bus
  logic              bus_req;
  logic              bus_we;
  logic [XLEN/8-1:0] bus_be;
  logic [ADDR_W-1:0] bus_addr;
  logic [XLEN-1:0]   bus_wdata;
  logic [XLEN-1:0]   bus_rdata;
  logic              bus_ack;

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output bus_req, bus_we, bus_be, bus_addr, bus_wdata,
    input  bus_rdata, bus_ack
  );

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  bus_req, bus_we, bus_be, bus_addr, bus_wdata,
    output bus_rdata, bus_ack
  );
endinterface

// File: rtl/lsu_handshake.sv
// ---------------------------------------------------------------------------
// lsu_handshake
//
// Load/store unit placed between the multi-cycle core sequencer and the
// byte-addressable memory.
//   - The core side is a valid/ready request port with a one-cycle response
//     pulse.
//   - The memory side is an ack-terminated bus, so memories of any latency
//     can be attached.
//   - The unit steers byte lanes, sign- or zero-extends loads, detects
//     misaligned and illegal-size accesses, and aborts with an error when
//     the bus does not acknowledge in time.
//
// Parameters:
//   XLEN    data width; must be 32 or 64.
//   ADDR_W  byte address width; must be at least 3.
//   TIMEOUT number of unacknowledged bus cycles before the access aborts;
//           must be at least 1.
//
// Ports:
//   clk  clock; all logic is rising-edge.
//   rst  asynchronous, active-low reset.
//   lsu  lsu_handshake_if.slave, which carries the request, response and
//        bus signals.
//
// Response codes (resp_err):
//   0 = ok, 1 = misaligned, 2 = timeout, 3 = illegal size.
//
// Optional feature, enabled by defining the macro LSU_MISALIGN_SPLIT_EN:
//   A misaligned access that crosses a word boundary runs as two bus beats,
//   in states BUS and then BUS2. Without the macro, every misaligned access
//   returns error 1 and causes no bus activity.
//
// Output timing: every output is registered except req_ready, which is
// decoded from the state.
// ---------------------------------------------------------------------------
module lsu_handshake #(
  parameter int XLEN    = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic           clk,
  input  logic           rst,
  lsu_handshake_if.slave lsu
);

  localparam int NB     = XLEN / 8;
  localparam int LANE_W = $clog2(NB);
  localparam int CNT_W  = $clog2(TIMEOUT + 1);

`ifdef LSU_MISALIGN_SPLIT_EN
  typedef enum logic [1:0] {IDLE, BUS, BUS2, RESP} state_t;
`else
  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;
`endif

  state_t state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;

  // request fields latched at accept
  logic              we_reg;
  logic [1:0]        size_reg;
  logic              unsigned_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [XLEN-1:0]   wdata_reg;
`ifdef LSU_MISALIGN_SPLIT_EN
  logic              two_beat_reg;
  logic [XLEN-1:0]   lo_data_reg;
`endif

  // registered outputs
  logic              bus_req_reg,    bus_req_next;
  logic              bus_we_reg,     bus_we_next;
  logic [NB-1:0]     bus_be_reg,     bus_be_next;
  logic [ADDR_W-1:0] bus_addr_reg,   bus_addr_next;
  logic [XLEN-1:0]   bus_wdata_reg,  bus_wdata_next;
  logic              resp_valid_reg, resp_valid_next;
  logic [XLEN-1:0]   resp_rdata_reg, resp_rdata_next;
  logic [1:0]        resp_err_reg,   resp_err_next;

  // -------------------------------------------------------------------------
  // Field source selection.
  // In IDLE the steering logic looks at the live request, so that the bus
  // outputs can be registered on the accepting edge. In every other state it
  // looks at the latched copy of the request.
  // -------------------------------------------------------------------------
  logic              is_idle;
  logic              src_we;
  logic [1:0]        src_size;
  logic              src_unsigned;
  logic [ADDR_W-1:0] src_addr;
  logic [XLEN-1:0]   src_wdata;

  assign is_idle = (state_reg == IDLE);

  always_comb begin
    if (is_idle) begin
      src_we       = lsu.req_we;
      src_size     = lsu.req_size;
      src_unsigned = lsu.req_unsigned;
      src_addr     = lsu.req_addr;
      src_wdata    = lsu.req_wdata;
    end else begin
      src_we       = we_reg;
      src_size     = size_reg;
      src_unsigned = unsigned_reg;
      src_addr     = addr_reg;
      src_wdata    = wdata_reg;
    end
  end

  logic [LANE_W-1:0] src_lane;
  logic [LANE_W+2:0] src_shift;   // byte lane expressed as a bit shift amount
  logic [3:0]        src_bytes;
  logic [2:0]        align_mask;
  logic              misaligned;
  logic              size_illegal;
  logic [ADDR_W-1:0] word_addr;
  logic              cnt_hit;

  assign src_lane     = src_addr[LANE_W-1:0];
  assign src_shift    = {src_lane, 3'b000};
  assign src_bytes    = 4'd1 << src_size;
  assign align_mask   = 3'((4'd1 << src_size) - 4'd1);
  assign misaligned   = |(src_addr[2:0] & align_mask);
  assign size_illegal = (XLEN == 32) && (src_size == 2'd3);
  assign word_addr    = {src_addr[ADDR_W-1:LANE_W], {LANE_W{1'b0}}};

  // The last permitted wait cycle: when this cycle also goes unacknowledged,
  // bus_req has been high for exactly TIMEOUT cycles.
  assign cnt_hit      = (cnt_reg == CNT_W'(TIMEOUT - 1));

  // -------------------------------------------------------------------------
  // Lane steering and load data alignment
  // -------------------------------------------------------------------------
  logic [NB-1:0]   be_lo;
  logic [XLEN-1:0] wdata_lo;
  logic [XLEN-1:0] load_raw;

`ifdef LSU_MISALIGN_SPLIT_EN
  // Double-width views. The upper half is what spills into the next word
  // and is therefore driven by the second beat.
  logic [2*NB-1:0]   be_wide;
  logic [2*XLEN-1:0] wdata_wide;
  logic [2*XLEN-1:0] data_wide;
  logic [NB-1:0]     be_hi;
  logic [XLEN-1:0]   wdata_hi;
  logic              crosses;

  assign be_wide    = (((2*NB)'(1) << src_bytes) - (2*NB)'(1)) << src_lane;
  assign wdata_wide = {{XLEN{1'b0}}, src_wdata} << src_shift;
  assign be_lo      = be_wide[NB-1:0];
  assign be_hi      = be_wide[2*NB-1:NB];
  assign wdata_lo   = wdata_wide[XLEN-1:0];
  assign wdata_hi   = wdata_wide[2*XLEN-1:XLEN];
  assign crosses    = (int'(src_lane) + int'(src_bytes)) > NB;

  // The second beat supplies the high word, placed above the first-beat data.
  assign data_wide  = (state_reg == BUS2) ? {lsu.bus_rdata, lo_data_reg}
                                          : {{XLEN{1'b0}}, lsu.bus_rdata};
  assign load_raw   = XLEN'(data_wide >> src_shift);
`else
  assign be_lo    = NB'(((2*NB)'(1) << src_bytes) - (2*NB)'(1)) << src_lane;
  assign wdata_lo = src_wdata << src_shift;
  assign load_raw = lsu.bus_rdata >> src_shift;
`endif

  // Truncate to the access size, then sign- or zero-extend.
  // mask ^ (mask >> 1) isolates the top bit of the access, which is the
  // sign bit.
  function automatic logic [XLEN-1:0] extend(input logic [XLEN-1:0] raw,
                                             input logic [1:0]      size,
                                             input logic            uns);
    logic [XLEN-1:0] mask;
    logic            sign;
    int              nbits;
    nbits = 8 << size;
    mask  = (nbits >= XLEN) ? {XLEN{1'b1}} : ((XLEN'(1) << nbits) - XLEN'(1));
    sign  = |(raw & (mask ^ (mask >> 1)));
    return (!uns && sign) ? (raw | ~mask) : (raw & mask);
  endfunction

  // -------------------------------------------------------------------------
  // State register, latched request fields and output registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      we_reg         <= 1'b0;
      size_reg       <= '0;
      unsigned_reg   <= 1'b0;
      addr_reg       <= '0;
      wdata_reg      <= '0;
`ifdef LSU_MISALIGN_SPLIT_EN
      two_beat_reg   <= 1'b0;
      lo_data_reg    <= '0;
`endif
      bus_req_reg    <= 1'b0;
      bus_we_reg     <= 1'b0;
      bus_be_reg     <= '0;
      bus_addr_reg   <= '0;
      bus_wdata_reg  <= '0;
      resp_valid_reg <= 1'b0;
      resp_rdata_reg <= '0;
      resp_err_reg   <= '0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      if (is_idle && lsu.req_valid) begin
        we_reg       <= lsu.req_we;
        size_reg     <= lsu.req_size;
        unsigned_reg <= lsu.req_unsigned;
        addr_reg     <= lsu.req_addr;
        wdata_reg    <= lsu.req_wdata;
`ifdef LSU_MISALIGN_SPLIT_EN
        two_beat_reg <= crosses && !size_illegal;
`endif
      end
`ifdef LSU_MISALIGN_SPLIT_EN
      if (state_reg == BUS && lsu.bus_ack) begin
        lo_data_reg  <= lsu.bus_rdata;
      end
`endif
      bus_req_reg    <= bus_req_next;
      bus_we_reg     <= bus_we_next;
      bus_be_reg     <= bus_be_next;
      bus_addr_reg   <= bus_addr_next;
      bus_wdata_reg  <= bus_wdata_next;
      resp_valid_reg <= resp_valid_next;
      resp_rdata_reg <= resp_rdata_next;
      resp_err_reg   <= resp_err_next;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic, including the per-beat timeout counter
  // -------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (lsu.req_valid) begin
          cnt_next = '0;
          if (size_illegal) begin
            state_next = RESP;
          end else begin
`ifdef LSU_MISALIGN_SPLIT_EN
            state_next = BUS;
`else
            state_next = misaligned ? RESP : BUS;
`endif
          end
        end
      end
      BUS: begin
        if (lsu.bus_ack) begin
`ifdef LSU_MISALIGN_SPLIT_EN
          if (two_beat_reg) begin
            state_next = BUS2;
            cnt_next   = '0;
          end else begin
            state_next = RESP;
          end
`else
          state_next = RESP;
`endif
        end else if (cnt_hit) begin
          state_next = RESP;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
`ifdef LSU_MISALIGN_SPLIT_EN
      BUS2: begin
        if (lsu.bus_ack || cnt_hit) begin
          state_next = RESP;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
`endif
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Output logic: next values of the registered outputs.
  // The bus outputs hold their values while waiting for bus_ack, and are
  // cleared whenever bus_req drops.
  // -------------------------------------------------------------------------
  always_comb begin
    bus_req_next    = bus_req_reg;
    bus_we_next     = bus_we_reg;
    bus_be_next     = bus_be_reg;
    bus_addr_next   = bus_addr_reg;
    bus_wdata_next  = bus_wdata_reg;
    resp_valid_next = 1'b0;
    resp_rdata_next = resp_rdata_reg;
    resp_err_next   = resp_err_reg;
    case (state_reg)
      IDLE: begin
        if (lsu.req_valid) begin
          if (size_illegal) begin
            resp_valid_next = 1'b1;
            resp_err_next   = 2'd3;
            resp_rdata_next = '0;
`ifndef LSU_MISALIGN_SPLIT_EN
          end else if (misaligned) begin
            resp_valid_next = 1'b1;
            resp_err_next   = 2'd1;
            resp_rdata_next = '0;
`endif
          end else begin
            bus_req_next    = 1'b1;
            bus_we_next     = src_we;
            bus_be_next     = be_lo;
            bus_addr_next   = word_addr;
            bus_wdata_next  = wdata_lo;
          end
        end
      end
      BUS: begin
        if (lsu.bus_ack) begin
`ifdef LSU_MISALIGN_SPLIT_EN
          if (two_beat_reg) begin
            bus_be_next    = be_hi;
            bus_addr_next  = word_addr + ADDR_W'(NB);
            bus_wdata_next = wdata_hi;
          end else begin
            bus_req_next    = 1'b0;
            bus_we_next     = 1'b0;
            bus_be_next     = '0;
            bus_addr_next   = '0;
            bus_wdata_next  = '0;
            resp_valid_next = 1'b1;
            resp_err_next   = 2'd0;
            resp_rdata_next = src_we ? '0 : extend(load_raw, src_size, src_unsigned);
          end
`else
          bus_req_next    = 1'b0;
          bus_we_next     = 1'b0;
          bus_be_next     = '0;
          bus_addr_next   = '0;
          bus_wdata_next  = '0;
          resp_valid_next = 1'b1;
          resp_err_next   = 2'd0;
          resp_rdata_next = src_we ? '0 : extend(load_raw, src_size, src_unsigned);
`endif
        end else if (cnt_hit) begin
          bus_req_next    = 1'b0;
          bus_we_next     = 1'b0;
          bus_be_next     = '0;
          bus_addr_next   = '0;
          bus_wdata_next  = '0;
          resp_valid_next = 1'b1;
          resp_err_next   = 2'd2;
          resp_rdata_next = '0;
        end
      end
`ifdef LSU_MISALIGN_SPLIT_EN
      BUS2: begin
        if (lsu.bus_ack || cnt_hit) begin
          bus_req_next    = 1'b0;
          bus_we_next     = 1'b0;
          bus_be_next     = '0;
          bus_addr_next   = '0;
          bus_wdata_next  = '0;
          resp_valid_next = 1'b1;
          if (lsu.bus_ack) begin
            resp_err_next   = 2'd0;
            resp_rdata_next = src_we ? '0 : extend(load_raw, src_size, src_unsigned);
          end else begin
            resp_err_next   = 2'd2;
            resp_rdata_next = '0;
          end
        end
      end
`endif
      default: ;
    endcase
  end

  assign lsu.req_ready  = is_idle;
  assign lsu.resp_valid = resp_valid_reg;
  assign lsu.resp_rdata = resp_rdata_reg;
  assign lsu.resp_err   = resp_err_reg;
  assign lsu.bus_req    = bus_req_reg;
  assign lsu.bus_we     = bus_we_reg;
  assign lsu.bus_be     = bus_be_reg;
  assign lsu.bus_addr   = bus_addr_reg;
  assign lsu.bus_wdata  = bus_wdata_reg;

endmodule

// File: tb/tb_lsu_handshake.sv
// ---------------------------------------------------------------------------
// tb_lsu_handshake
//
// Directed bench for lsu_handshake, configured with XLEN=32, ADDR_W=32 and
// TIMEOUT=4.
//
// Inputs are driven on the falling clock edge, and outputs are sampled on
// the falling edge as well, so nothing is sampled at the active edge.
//
// The macro LSU_MISALIGN_SPLIT_EN selects the expected behaviour for
// misaligned accesses.
// ---------------------------------------------------------------------------
module tb_lsu_handshake;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  lsu_handshake_if #(.XLEN(32), .ADDR_W(32)) lif ();

  lsu_handshake #(.XLEN(32), .ADDR_W(32), .TIMEOUT(4)) dut (
    .clk (clk),
    .rst (rst),
    .lsu (lif.slave)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  // Present one request at a falling edge while the unit is idle. The
  // request is accepted on the following rising edge, and the task returns
  // in the first cycle after that accepting edge.
  task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata);
    check("req_ready_before_accept", 64'(lif.req_ready), 64'd1);
    $display("txn we=%0d size=%0d unsigned=%0d addr=0x%08h wdata=0x%08h",
             we, size, uns, addr, wdata);
    lif.req_valid    = 1'b1;
    lif.req_we       = we;
    lif.req_size     = size;
    lif.req_unsigned = uns;
    lif.req_addr     = addr;
    lif.req_wdata    = wdata;
    tick;
    lif.req_valid    = 1'b0;
  endtask

  initial begin
    rst              = 1'b0;
    lif.req_valid    = 1'b0;
    lif.req_we       = 1'b0;
    lif.req_size     = 2'd0;
    lif.req_unsigned = 1'b0;
    lif.req_addr     = '0;
    lif.req_wdata    = '0;
    lif.bus_rdata    = '0;
    lif.bus_ack      = 1'b0;
    tick;
    tick;

    // reset values
    check("rst_req_ready",  64'(lif.req_ready),  64'd1);
    check("rst_bus_req",    64'(lif.bus_req),    64'd0);
    check("rst_bus_be",     64'(lif.bus_be),     64'd0);
    check("rst_resp_valid", 64'(lif.resp_valid), 64'd0);
    check("rst_resp_err",   64'(lif.resp_err),   64'd0);
    check("rst_resp_rdata", 64'(lif.resp_rdata), 64'd0);
    rst = 1'b1;
    tick;

    // aligned word load at 0x10, acknowledged in the first BUS cycle
    issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    check("w_bus_req",    64'(lif.bus_req),    64'd1);
    check("w_bus_be",     64'(lif.bus_be),     64'hF);
    check("w_bus_addr",   64'(lif.bus_addr),   64'h10);
    check("w_bus_we",     64'(lif.bus_we),     64'd0);
    check("w_ready_busy", 64'(lif.req_ready),  64'd0);
    check("w_no_resp",    64'(lif.resp_valid), 64'd0);
    lif.bus_ack   = 1'b1;
    lif.bus_rdata = 32'h80FF1234;
    tick;
    lif.bus_ack   = 1'b0;
    check("w_resp_valid", 64'(lif.resp_valid), 64'd1);
    check("w_resp_rdata", 64'(lif.resp_rdata), 64'h80FF1234);
    check("w_resp_err",   64'(lif.resp_err),   64'd0);
    check("w_bus_dropped",64'(lif.bus_req),    64'd0);
    check("w_ready_resp", 64'(lif.req_ready),  64'd0);
    tick;
    check("w_resp_pulse", 64'(lif.resp_valid), 64'd0);

    // signed byte load at 0x13
    issue(1'b0, 2'd0, 1'b0, 32'h13, 32'h0);
    check("bs_bus_be",   64'(lif.bus_be),   64'h8);
    check("bs_bus_addr", 64'(lif.bus_addr), 64'h10);
    lif.bus_ack = 1'b1;
    tick;
    lif.bus_ack = 1'b0;
    check("bs_resp_valid", 64'(lif.resp_valid), 64'd1);
    check("bs_resp_rdata", 64'(lif.resp_rdata), 64'hFFFFFF80);
    tick;

    // the same byte load, unsigned
    issue(1'b0, 2'd0, 1'b1, 32'h13, 32'h0);
    lif.bus_ack = 1'b1;
    tick;
    lif.bus_ack = 1'b0;
    check("bu_resp_valid", 64'(lif.resp_valid), 64'd1);
    check("bu_resp_rdata", 64'(lif.resp_rdata), 64'h00000080);
    tick;

    // half store at 0x22 with the ack delayed until the 4th BUS cycle
    issue(1'b1, 2'd1, 1'b0, 32'h22, 32'h0000BEEF);
    for (int i = 0; i < 4; i++) begin
      check("hs_bus_req",   64'(lif.bus_req),    64'd1);
      check("hs_bus_we",    64'(lif.bus_we),     64'd1);
      check("hs_bus_be",    64'(lif.bus_be),     64'hC);
      check("hs_bus_addr",  64'(lif.bus_addr),   64'h20);
      check("hs_bus_wdata", 64'(lif.bus_wdata),  64'hBEEF0000);
      check("hs_no_resp",   64'(lif.resp_valid), 64'd0);
      if (i == 3) lif.bus_ack = 1'b1;
      tick;
    end
    lif.bus_ack = 1'b0;
    check("hs_resp_valid", 64'(lif.resp_valid), 64'd1);
    check("hs_resp_err",   64'(lif.resp_err),   64'd0);
    check("hs_resp_rdata", 64'(lif.resp_rdata), 64'd0);
    tick;

    // misaligned word load at 0x05
`ifdef LSU_MISALIGN_SPLIT_EN
    issue(1'b0, 2'd2, 1'b0, 32'h05, 32'h0);
    check("ms_beat1_req",  64'(lif.bus_req),  64'd1);
    check("ms_beat1_be",   64'(lif.bus_be),   64'hE);
    check("ms_beat1_addr", 64'(lif.bus_addr), 64'h04);
    lif.bus_ack   = 1'b1;
    lif.bus_rdata = 32'hDDCCBBAA;
    tick;
    check("ms_beat2_req",  64'(lif.bus_req),    64'd1);
    check("ms_beat2_be",   64'(lif.bus_be),     64'h1);
    check("ms_beat2_addr", 64'(lif.bus_addr),   64'h08);
    check("ms_no_resp",    64'(lif.resp_valid), 64'd0);
    lif.bus_rdata = 32'h44332211;
    tick;
    lif.bus_ack   = 1'b0;
    check("ms_resp_valid", 64'(lif.resp_valid), 64'd1);
    check("ms_resp_err",   64'(lif.resp_err),   64'd0);
    check("ms_resp_rdata", 64'(lif.resp_rdata), 64'h11DDCCBB);
    check("ms_bus_done",   64'(lif.bus_req),    64'd0);
    tick;
`else
    issue(1'b0, 2'd2, 1'b0, 32'h05, 32'h0);
    check("ma_resp_valid", 64'(lif.resp_valid), 64'd1);
    check("ma_resp_err",   64'(lif.resp_err),   64'd1);
    check("ma_resp_rdata", 64'(lif.resp_rdata), 64'd0);
    check("ma_no_bus",     64'(lif.bus_req),    64'd0);
    tick;
    check("ma_no_bus_after", 64'(lif.bus_req),  64'd0);
    check("ma_resp_pulse",   64'(lif.resp_valid), 64'd0);
`endif

    // illegal size (dword with XLEN=32)
    issue(1'b0, 2'd3, 1'b0, 32'h40, 32'h0);
    check("il_resp_valid", 64'(lif.resp_valid), 64'd1);
    check("il_resp_err",   64'(lif.resp_err),   64'd3);
    check("il_no_bus",     64'(lif.bus_req),    64'd0);
    tick;

    // timeout: no ack for TIMEOUT=4 cycles
    issue(1'b0, 2'd2, 1'b0, 32'h30, 32'h0);
    for (int i = 0; i < 4; i++) begin
      check("to_bus_req_high", 64'(lif.bus_req),    64'd1);
      check("to_no_resp",      64'(lif.resp_valid), 64'd0);
      tick;
    end
    check("to_bus_req_low", 64'(lif.bus_req),    64'd0);
    check("to_resp_valid",  64'(lif.resp_valid), 64'd1);
    check("to_resp_err",    64'(lif.resp_err),   64'd2);
    check("to_resp_rdata",  64'(lif.resp_rdata), 64'd0);
    lif.bus_ack   = 1'b1;   // late ack, must be ignored
    lif.bus_rdata = 32'h12345678;
    tick;
    lif.bus_ack   = 1'b0;
    check("to_late_ack_resp",  64'(lif.resp_valid), 64'd0);
    check("to_late_ack_bus",   64'(lif.bus_req),    64'd0);
    check("to_late_ack_ready", 64'(lif.req_ready),  64'd1);

    // asynchronous reset in the middle of a BUS cycle
    issue(1'b0, 2'd2, 1'b0, 32'h50, 32'h0);
    check("rb_bus_req", 64'(lif.bus_req), 64'd1);
    #2 rst = 1'b0;
    #1;
    check("rb_bus_req_async", 64'(lif.bus_req),   64'd0);
    check("rb_ready_async",   64'(lif.req_ready), 64'd1);
    lif.bus_ack = 1'b1;
    tick;
    check("rb_no_resp_in_rst", 64'(lif.resp_valid), 64'd0);
    rst = 1'b1;
    tick;
    lif.bus_ack = 1'b0;
    check("rb_no_resp_after", 64'(lif.resp_valid), 64'd0);
    check("rb_ready_after",   64'(lif.req_ready),  64'd1);
    check("rb_bus_idle",      64'(lif.bus_req),    64'd0);

    // the unit still works after the reset
    issue(1'b0, 2'd1, 1'b0, 32'h12, 32'h0);
    check("pr_bus_be", 64'(lif.bus_be), 64'hC);
    lif.bus_ack   = 1'b1;
    lif.bus_rdata = 32'h7FFF0000;
    tick;
    lif.bus_ack   = 1'b0;
    check("pr_resp_rdata", 64'(lif.resp_rdata), 64'h00007FFF);
    tick;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
